// File: rtl/led_frame_scheduler.sv
// LED frame scheduler: arbitrates three display sources round-robin,
// serialises the winning 16-bit word onto an LED shift chain, strobes the
// chain latch, then enforces a fixed idle gap before the next frame.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no frame in flight; arbitrate whenever any request is set
// SHIFT | 16 cycles shifting the captured word out (bits 8..15, 0..7)
// LATCH | one cycle of latch strobe (low) and ack to the owner
// HOLD  | HOLD_CYCLES quiet cycles before arbitration resumes
module led_frame_scheduler #(
  parameter int HOLD_CYCLES = 16
) (
  input  logic        i_CLK,
  input  logic        i_RESET,
  input  logic [2:0]  i_Req,
  input  logic [15:0] i_Data0,
  input  logic [15:0] i_Data1,
  input  logic [15:0] i_Data2,
  output logic [2:0]  o_Grant,
  output logic [2:0]  o_Ack,
  output logic        o_Busy,
  output logic        o_LEDData,
  output logic        o_LEDShift,
  output logic        o_LEDLatch
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // Last HOLD count value; unused when the hold gap is disabled.
  localparam logic [7:0] HOLD_LAST = (HOLD_CYCLES == 0) ? 8'd0 : 8'(HOLD_CYCLES - 1);
  localparam bit         HOLD_EN   = (HOLD_CYCLES != 0);

  state_t      state_q, state_d;
  logic [3:0]  pos_q, pos_d;
  logic [7:0]  hold_q, hold_d;
  logic [15:0] shadow_q, shadow_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  ptr_q, ptr_d;

  logic [2:0]  grant_q, grant_d;
  logic [2:0]  ack_q, ack_d;
  logic        busy_q, busy_d;
  logic        led_data_q, led_data_d;
  logic        led_shift_q, led_shift_d;
  logic        led_latch_q, led_latch_d;

  logic [1:0]  pick;
  logic [15:0] pick_data;

  // Round-robin: search starts at ptr and wraps 2 -> 0.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] sel;
    sel = 2'd0;
    case (ptr)
      2'd1:    sel = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd2:    sel = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: sel = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
    return sel;
  endfunction

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  function automatic logic [2:0] one_hot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  // Arbitration winner and its display word.
  always_comb begin
    pick      = rr_pick(i_Req, ptr_q);
    pick_data = i_Data0;
    case (pick)
      2'd1:    pick_data = i_Data1;
      2'd2:    pick_data = i_Data2;
      default: pick_data = i_Data0;
    endcase
  end

  // Next-state logic for the frame sequencer and its counters.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    hold_d   = hold_q;
    shadow_d = shadow_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (|i_Req) begin
          state_d  = S_SHIFT;
          pos_d    = 4'd0;
          shadow_d = pick_data;
          owner_d  = pick;
          ptr_d    = rr_next(pick);
        end
      end
      S_SHIFT: begin
        if (pos_q == 4'd15) begin
          state_d = S_LATCH;
        end else begin
          pos_d = pos_q + 4'd1;
        end
      end
      S_LATCH: begin
        if (HOLD_EN) begin
          state_d = S_HOLD;
          hold_d  = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state so the
  // registered outputs line up with the state they describe.
  always_comb begin
    grant_d     = 3'b000;
    ack_d       = 3'b000;
    busy_d      = (state_d != S_IDLE);
    led_data_d  = 1'b0;
    led_shift_d = 1'b0;
    led_latch_d = 1'b1;
    case (state_d)
      S_SHIFT: begin
        grant_d     = one_hot(owner_d);
        led_shift_d = 1'b1;
        // pos XOR 8 sends the upper byte first, then the lower byte.
        led_data_d  = shadow_d[pos_d ^ 4'd8];
      end
      S_LATCH: begin
        grant_d     = one_hot(owner_d);
        ack_d       = one_hot(owner_d);
        led_latch_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      state_q  <= S_IDLE;
      pos_q    <= 4'd0;
      hold_q   <= 8'd0;
      shadow_q <= 16'd0;
      owner_q  <= 2'd0;
      ptr_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      hold_q   <= hold_d;
      shadow_q <= shadow_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
    end
  end

  // Output registers; reset forces the idle, latch-inactive pattern.
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      grant_q     <= 3'b000;
      ack_q       <= 3'b000;
      busy_q      <= 1'b0;
      led_data_q  <= 1'b0;
      led_shift_q <= 1'b0;
      led_latch_q <= 1'b1;
    end else begin
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      led_data_q  <= led_data_d;
      led_shift_q <= led_shift_d;
      led_latch_q <= led_latch_d;
    end
  end

  assign o_Grant    = grant_q;
  assign o_Ack      = ack_q;
  assign o_Busy     = busy_q;
  assign o_LEDData  = led_data_q;
  assign o_LEDShift = led_shift_q;
  assign o_LEDLatch = led_latch_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed bench for led_frame_scheduler: one instance with the default hold
// gap and one with the gap disabled, driven from a single clock.
module tb_led_frame_scheduler;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [15:0] data0, data1, data2;
  logic [2:0]  o_grant, o_ack;
  logic        o_busy, o_led_data, o_led_shift, o_led_latch;

  logic [2:0]  req_b;
  logic [15:0] data_b;
  logic [2:0]  o_grant_b, o_ack_b;
  logic        o_busy_b, o_led_data_b, o_led_shift_b, o_led_latch_b;

  int n_checks = 0;
  int n_fail   = 0;

  led_frame_scheduler #(.HOLD_CYCLES(16)) dut (
    .i_CLK(clk), .i_RESET(rst), .i_Req(req),
    .i_Data0(data0), .i_Data1(data1), .i_Data2(data2),
    .o_Grant(o_grant), .o_Ack(o_ack), .o_Busy(o_busy),
    .o_LEDData(o_led_data), .o_LEDShift(o_led_shift), .o_LEDLatch(o_led_latch)
  );

  led_frame_scheduler #(.HOLD_CYCLES(0)) dut0 (
    .i_CLK(clk), .i_RESET(rst), .i_Req(req_b),
    .i_Data0(data_b), .i_Data1(data_b), .i_Data2(data_b),
    .o_Grant(o_grant_b), .o_Ack(o_ack_b), .o_Busy(o_busy_b),
    .o_LEDData(o_led_data_b), .o_LEDShift(o_led_shift_b), .o_LEDLatch(o_led_latch_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Waits for a frame to start shifting, collects its serial stream (first bit
  // in the MSB), then checks the latch/ack cycle and the cycle after it.
  task automatic run_frame(input string tag, input logic [2:0] exp_g,
                           input logic [15:0] exp_stream,
                           input int chg_pos, input logic [15:0] chg_val);
    int n;
    int shifts;
    logic [15:0] got;
    n = 0;
    while (!o_led_shift && n < 100) begin
      tick();
      n++;
    end
    check_eq({tag, " shift_seen"}, 32'(o_led_shift), 32'd1);
    check_eq({tag, " grant"}, 32'(o_grant), 32'(exp_g));
    shifts = 0;
    got = 16'd0;
    while (o_led_shift && shifts < 40) begin
      got = {got[14:0], o_led_data};
      if (shifts == chg_pos) data0 = chg_val;
      shifts++;
      tick();
    end
    check_eq({tag, " shift_count"}, 32'(shifts), 32'd16);
    check_eq({tag, " stream"}, 32'(got), 32'(exp_stream));
    check_eq({tag, " latch_low"}, 32'(o_led_latch), 32'd0);
    check_eq({tag, " ack"}, 32'(o_ack), 32'(exp_g));
    tick();
    check_eq({tag, " ack_pulse_end"}, 32'(o_ack), 32'd0);
    check_eq({tag, " latch_release"}, 32'(o_led_latch), 32'd1);
    check_eq({tag, " grant_clear"}, 32'(o_grant), 32'd0);
  endtask

  initial begin
    int n;
    logic saw_ack, saw_latch;
    rst = 1'b1;
    req = 3'b000;
    data0 = 16'h0000; data1 = 16'h0000; data2 = 16'h0000;
    req_b = 3'b000;
    data_b = 16'h1234;

    // Reset state
    tick();
    tick();
    check_eq("rst grant", 32'(o_grant), 32'd0);
    check_eq("rst ack", 32'(o_ack), 32'd0);
    check_eq("rst busy", 32'(o_busy), 32'd0);
    check_eq("rst led_data", 32'(o_led_data), 32'd0);
    check_eq("rst led_shift", 32'(o_led_shift), 32'd0);
    check_eq("rst led_latch", 32'(o_led_latch), 32'd1);

    // Single frame from source 0, A5C3; request dropped mid-frame
    rst = 1'b0;
    req = 3'b001;
    data0 = 16'hA5C3;
    tick();
    check_eq("a5c3 latency shift", 32'(o_led_shift), 32'd1);
    req = 3'b000;
    run_frame("a5c3", 3'b001, 16'b1010_0101_1100_0011, -1, 16'h0000);
    check_eq("hold busy", 32'(o_busy), 32'd1);
    repeat (15) tick();
    check_eq("hold last busy", 32'(o_busy), 32'd1);
    tick();
    check_eq("hold done idle", 32'(o_busy), 32'd0);
    repeat (10) tick();
    check_eq("idle stays busy", 32'(o_busy), 32'd0);
    check_eq("idle stays shift", 32'(o_led_shift), 32'd0);
    check_eq("idle stays latch", 32'(o_led_latch), 32'd1);

    // Three sources held: round-robin order and wrap
    req = 3'b111;
    data0 = 16'h1234; data1 = 16'h0100; data2 = 16'h0080;
    do_reset();
    tick();
    check_eq("rr first edge shift", 32'(o_led_shift), 32'd1);
    run_frame("rr0", 3'b001, 16'h482C, -1, 16'h0000);
    run_frame("rr1", 3'b010, 16'h8000, -1, 16'h0000);
    run_frame("rr2", 3'b100, 16'h0001, -1, 16'h0000);
    run_frame("rr_wrap", 3'b001, 16'h482C, -1, 16'h0000);
    req = 3'b000;

    // Data change at pos 5 must not disturb the captured word
    do_reset();
    req = 3'b001;
    data0 = 16'hFF00;
    tick();
    req = 3'b000;
    run_frame("capture", 3'b001, 16'hFF00, 5, 16'h00FF);

    // Request arriving during HOLD waits for the gap to finish
    n = 0;
    while (!o_led_shift && n < 60) begin
      if (n == 2) req = 3'b010;
      tick();
      n++;
    end
    check_eq("hold req wait", 32'(n), 32'd17);
    run_frame("hold_req", 3'b010, 16'h8000, -1, 16'h0000);
    req = 3'b000;

    // Asynchronous reset at pos 9 aborts the frame
    do_reset();
    req = 3'b001;
    data0 = 16'hFFFF;
    tick();
    req = 3'b000;
    repeat (9) tick();
    check_eq("abort pre shift", 32'(o_led_shift), 32'd1);
    check_eq("abort pre data", 32'(o_led_data), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("abort grant", 32'(o_grant), 32'd0);
    check_eq("abort ack", 32'(o_ack), 32'd0);
    check_eq("abort busy", 32'(o_busy), 32'd0);
    check_eq("abort led_data", 32'(o_led_data), 32'd0);
    check_eq("abort led_shift", 32'(o_led_shift), 32'd0);
    check_eq("abort led_latch", 32'(o_led_latch), 32'd1);
    saw_ack = 1'b0;
    saw_latch = 1'b0;
    repeat (3) begin
      tick();
      if (o_ack != 3'b000) saw_ack = 1'b1;
      if (!o_led_latch) saw_latch = 1'b1;
    end
    rst = 1'b0;
    repeat (30) begin
      tick();
      if (o_ack != 3'b000) saw_ack = 1'b1;
      if (!o_led_latch) saw_latch = 1'b1;
    end
    check_eq("abort no ack", 32'(saw_ack), 32'd0);
    check_eq("abort no latch", 32'(saw_latch), 32'd0);

    // Zero hold gap: consecutive latches 18 cycles apart
    req_b = 3'b010;
    n = 0;
    while (o_led_latch_b && n < 100) begin
      tick();
      n++;
    end
    check_eq("h0 first latch", 32'(o_led_latch_b), 32'd0);
    check_eq("h0 first ack", 32'(o_ack_b), 32'b010);
    tick();
    n = 1;
    while (o_led_latch_b && n < 100) begin
      tick();
      n++;
    end
    check_eq("h0 latch spacing", 32'(n), 32'd18);
    check_eq("h0 second ack", 32'(o_ack_b), 32'b010);
    check_eq("h0 busy", 32'(o_busy_b), 32'd1);
    req_b = 3'b000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
